// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_if
// Description : Compare/branch request and PC-redirect bundle for branch_resolve.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_if #(
    parameter int BIT_COUNT     = 8,
    parameter int BC_FLAG_COUNT = 2
);
    logic                     cmp_valid;
    logic [BC_FLAG_COUNT-1:0] bc_flags;
    logic                     br_valid;
    logic                     br_ready;
    logic [2:0]               br_cond;
    logic [BIT_COUNT-1:0]     br_pc;
    logic [BIT_COUNT-1:0]     br_offset;
    logic                     pc_load;
    logic [BIT_COUNT-1:0]     pc_target;
    logic                     br_taken;
    logic                     br_done;
    logic                     flush;
    logic [BC_FLAG_COUNT-1:0] flags_q;

    modport master (
        output cmp_valid, bc_flags, br_valid, br_cond, br_pc, br_offset,
        input  br_ready, pc_load, pc_target, br_taken, br_done, flush, flags_q
    );

    modport slave (
        input  cmp_valid, bc_flags, br_valid, br_cond, br_pc, br_offset,
        output br_ready, pc_load, pc_target, br_taken, br_done, flush, flags_q
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Latches comparator flags, resolves conditional branches,
//               issues the PC load and a fixed-length pipeline flush.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int BIT_COUNT     = 8,
    parameter int BC_FLAG_COUNT = 2,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus
);
    localparam int c_FLAG_EQ = 0;
    localparam int c_FLAG_GT = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [BC_FLAG_COUNT-1:0] r_flags;
    logic [3:0]               r_count;
    logic [2:0]               r_cond;
    logic [BIT_COUNT-1:0]     r_pc;
    logic [BIT_COUNT-1:0]     r_offset;
    logic [BIT_COUNT-1:0]     r_target;

    logic                     w_eq;
    logic                     w_gt;
    logic                     w_cond_true;
    logic                     w_resolve;
    logic                     w_load;
    logic [BIT_COUNT-1:0]     w_sum;

    assign w_eq = r_flags[c_FLAG_EQ];
    assign w_gt = r_flags[c_FLAG_GT];

    always_comb begin
        w_cond_true = 1'b0;
        case (r_cond)
            3'b000:  w_cond_true = 1'b1;
            3'b001:  w_cond_true = w_eq;
            3'b010:  w_cond_true = ~w_eq;
            3'b011:  w_cond_true = w_gt;
            3'b100:  w_cond_true = ~w_gt;
            3'b101:  w_cond_true = w_gt | w_eq;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Equal-width add: the offset's sign extension is implicit and the carry drops out.
    assign w_sum     = r_pc + r_offset;
    assign w_resolve = (r_state == S_RESOLVE);
    assign w_load    = w_resolve & w_cond_true;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_flags  <= '0;
            r_count  <= 4'd0;
            r_cond   <= 3'd0;
            r_pc     <= '0;
            r_offset <= '0;
            r_target <= '0;
        end else begin
            // A compare arriving during a flush belongs to a squashed instruction.
            if (bus.cmp_valid && r_state != S_FLUSH) begin
                r_flags <= bus.bc_flags;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.br_valid) begin
                        r_cond   <= bus.br_cond;
                        r_pc     <= bus.br_pc;
                        r_offset <= bus.br_offset;
                        r_state  <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    if (w_cond_true) begin
                        r_target <= w_sum;
                        r_count  <= 4'(FLUSH_CYCLES);
                        r_state  <= S_FLUSH;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    r_count <= r_count - 4'd1;
                    if (r_count <= 4'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.br_ready  = ~rst & (r_state == S_IDLE);
    assign bus.pc_load   = w_load;
    assign bus.pc_target = w_load ? w_sum : r_target;
    assign bus.br_taken  = w_load;
    assign bus.br_done   = w_resolve;
    assign bus.flush     = (r_state == S_FLUSH);
    assign bus.flags_q   = r_flags;
endmodule
`default_nettype wire
